instr_fetch_unit: RTL and testbench

//  Multi-cycle instruction fetch/issue sequencer: the initiator side of the Op interface.

---
 rtl/instr_fetch_unit.sv | 124 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Multi-cycle instruction fetch/issue sequencer: fetches a word, presents its opcode,
// waits for the datapath to finish, then advances PC sequentially or to a branch target.
module instr_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = 4
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [6:0]      Op,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc,
  output logic            instr_valid,
  input  logic            ex_done,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic            halted,
  output logic            illegal_op,
  output logic            misaligned
);

  typedef enum logic [1:0] {
    FETCH,
    ISSUE,
    EXEC,
    HALT
  } state_t;

  state_t          state, state_n;
  logic [XLEN-1:0] pc_n;
  logic [31:0]     ir, ir_n;
  logic            req_n, valid_n, halted_n, illegal_n, misaligned_n;
  logic            legal;

  assign instr     = ir;
  assign Op        = ir[6:0];
  assign imem_addr = pc;

  // Supported opcodes: R-type, LW, SW, BEQ
  always_comb begin
    legal = 1'b0;
    case (imem_rdata[6:0])
      7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011: legal = 1'b1;
      default:                                          legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      ir          <= '0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      illegal_op  <= 1'b0;
      misaligned  <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      ir          <= ir_n;
      imem_req    <= req_n;
      instr_valid <= valid_n;
      halted      <= halted_n;
      illegal_op  <= illegal_n;
      misaligned  <= misaligned_n;
    end
  end

  // Outputs are computed one cycle ahead so every output comes straight from a flop
  always_comb begin
    state_n      = state;
    pc_n         = pc;
    ir_n         = ir;
    req_n        = 1'b0;
    valid_n      = 1'b0;
    halted_n     = halted;
    illegal_n    = illegal_op;
    misaligned_n = misaligned;
    case (state)
      FETCH: begin
        req_n = 1'b1;
        // An ack only counts while the request is actually visible on the bus
        if (imem_req && imem_ack) begin
          ir_n  = imem_rdata;
          req_n = 1'b0;
          if (legal) begin
            state_n = ISSUE;
            valid_n = 1'b1;
          end else begin
            state_n   = HALT;
            halted_n  = 1'b1;
            illegal_n = 1'b1;
          end
        end
      end
      ISSUE: state_n = EXEC;
      EXEC: begin
        if (ex_done) begin
          if (!branch_taken) begin
            pc_n    = pc + XLEN'(PC_STEP);
            state_n = FETCH;
            req_n   = 1'b1;
          end else if (branch_target[1:0] == 2'b00) begin
            pc_n    = branch_target;
            state_n = FETCH;
            req_n   = 1'b1;
          end else begin
            state_n      = HALT;
            halted_n     = 1'b1;
            misaligned_n = 1'b1;
          end
        end
      end
      HALT:    state_n = HALT;
      default: state_n = FETCH;
    endcase
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a table of directed instructions, hand-written
// reset corner cases, and a randomized program checked against an ISA-level PC model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [6:0]  Op;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        instr_valid;
  logic        ex_done;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        halted;
  logic        illegal_op;
  logic        misaligned;

  int compared   = 0;
  int mismatched = 0;

  localparam int KIND_OK = 0, KIND_ILLEGAL = 1, KIND_MISALIGNED = 2;

  typedef struct {
    logic [31:0] word;
    int          ackDelay;
    int          exDelay;
    bit          taken;
    logic [31:0] target;
    logic [31:0] expPc;
    logic [6:0]  expOp;
    int          expKind;
    logic [31:0] expNext;
  } vec_t;

  instr_fetch_unit dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .Op(Op), .instr(instr), .pc(pc), .instr_valid(instr_valid),
    .ex_done(ex_done), .branch_taken(branch_taken), .branch_target(branch_target),
    .halted(halted), .illegal_op(illegal_op), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic doReset();
    reset = 1'b1; imem_ack = 1'b0; ex_done = 1'b0; branch_taken = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic bit isLegal(input logic [6:0] op);
    return op == 7'b0110011 || op == 7'b0000011 || op == 7'b0100011 || op == 7'b1100011;
  endfunction

  // Runs one instruction through fetch, issue and execute; called at a negedge
  task automatic applyStimulus(input vec_t v);
    int n = 0;
    while (!imem_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    checkOutput("fetch_req", {31'b0, imem_req}, 32'd1);
    checkOutput("fetch_addr", imem_addr, v.expPc);
    for (int i = 0; i < v.ackDelay; i++) begin
      imem_ack = 1'b0;
      @(negedge clk);
      checkOutput("wait_req", {31'b0, imem_req}, 32'd1);
      checkOutput("wait_addr", imem_addr, v.expPc);
    end
    imem_ack = 1'b1;
    imem_rdata = v.word;
    @(negedge clk);
    imem_ack = 1'b0;
    imem_rdata = $urandom;
    if (v.expKind == KIND_ILLEGAL) begin
      checkOutput("ill_halted", {31'b0, halted}, 32'd1);
      checkOutput("ill_flag", {31'b0, illegal_op}, 32'd1);
      checkOutput("ill_instr", instr, v.word);
      for (int i = 0; i < 3; i++) begin
        checkOutput("ill_valid", {31'b0, instr_valid}, 32'd0);
        checkOutput("ill_req", {31'b0, imem_req}, 32'd0);
        @(negedge clk);
      end
      return;
    end
    checkOutput("issue_valid", {31'b0, instr_valid}, 32'd1);
    checkOutput("issue_op", {25'b0, Op}, {25'b0, v.expOp});
    checkOutput("issue_instr", instr, v.word);
    checkOutput("issue_pc", pc, v.expPc);
    // ex_done during ISSUE must be ignored, even with a misaligned branch
    ex_done = 1'b1; branch_taken = 1'b1; branch_target = 32'h3;
    @(negedge clk);
    ex_done = 1'b0; branch_taken = 1'b0;
    checkOutput("exec_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("exec_halted", {31'b0, halted}, 32'd0);
    checkOutput("exec_op", {25'b0, Op}, {25'b0, v.expOp});
    checkOutput("exec_pc", pc, v.expPc);
    for (int i = 0; i < v.exDelay; i++) begin
      branch_taken = 1'b1; branch_target = 32'h2;
      @(negedge clk);
      checkOutput("exwait_req", {31'b0, imem_req}, 32'd0);
      checkOutput("exwait_pc", pc, v.expPc);
    end
    ex_done = 1'b1; branch_taken = v.taken; branch_target = v.target;
    @(negedge clk);
    ex_done = 1'b0; branch_taken = 1'b0;
    if (v.expKind == KIND_MISALIGNED) begin
      checkOutput("mis_halted", {31'b0, halted}, 32'd1);
      checkOutput("mis_flag", {31'b0, misaligned}, 32'd1);
      checkOutput("mis_illegal", {31'b0, illegal_op}, 32'd0);
      checkOutput("mis_pc", pc, v.expPc);
      @(negedge clk);
      checkOutput("mis_req", {31'b0, imem_req}, 32'd0);
    end else begin
      checkOutput("next_req", {31'b0, imem_req}, 32'd1);
      checkOutput("next_addr", imem_addr, v.expNext);
      checkOutput("next_halted", {31'b0, halted}, 32'd0);
    end
  endtask

  initial begin
    vec_t table_v[$];
    vec_t v;
    logic [31:0] mpc;
    logic [31:0] rnd;
    logic [6:0]  op;
    logic [6:0]  legalOps[4];

    legalOps = '{7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011};
    imem_rdata = '0; branch_target = '0;

    //           word          ack ex taken target        pc            op          kind          next
    table_v.push_back('{32'h003100B3, 0, 0, 1'b0, 32'h0,        32'h0,        7'b0110011, KIND_OK,      32'h4});
    table_v.push_back('{32'h00012083, 2, 1, 1'b0, 32'h0,        32'h4,        7'b0000011, KIND_OK,      32'h8});
    table_v.push_back('{32'h00208463, 0, 3, 1'b1, 32'h40,       32'h8,        7'b1100011, KIND_OK,      32'h40});
    table_v.push_back('{32'h00112023, 5, 0, 1'b1, 32'hFFFFFFFC, 32'h40,       7'b0100011, KIND_OK,      32'hFFFFFFFC});
    table_v.push_back('{32'h003100B3, 1, 0, 1'b0, 32'h0,        32'hFFFFFFFC, 7'b0110011, KIND_OK,      32'h0});
    table_v.push_back('{32'h00208463, 0, 0, 1'b0, 32'h40,       32'h0,        7'b1100011, KIND_OK,      32'h4});
    table_v.push_back('{32'h00000013, 0, 0, 1'b0, 32'h0,        32'h4,        7'b0010011, KIND_ILLEGAL, 32'h0});

    reset = 1'b1; imem_ack = 1'b0; ex_done = 1'b0; branch_taken = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_req", {31'b0, imem_req}, 32'd0);
    checkOutput("rst_pc", pc, 32'h0);
    checkOutput("rst_instr", instr, 32'h0);
    checkOutput("rst_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("rst_flags", {29'b0, halted, illegal_op, misaligned}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_req_rise", {31'b0, imem_req}, 32'd1);

    foreach (table_v[i]) applyStimulus(table_v[i]);

    // Misaligned branch target halts with pc frozen; reset clears every flag
    doReset();
    applyStimulus('{32'h00208463, 0, 0, 1'b1, 32'h42, 32'h0, 7'b1100011, KIND_MISALIGNED, 32'h0});
    doReset();
    checkOutput("clr_flags", {29'b0, halted, illegal_op, misaligned}, 32'd0);
    @(negedge clk);
    checkOutput("clr_addr", imem_addr, 32'h0);

    // Reset while a fetch is outstanding abandons it; an ack after reset is ignored
    applyStimulus('{32'h00208463, 0, 0, 1'b1, 32'h40, 32'h0, 7'b1100011, KIND_OK, 32'h40});
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midrst_req", {31'b0, imem_req}, 32'd0);
    checkOutput("midrst_pc", pc, 32'h0);
    reset = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'h00000013;
    @(negedge clk);
    imem_ack = 1'b0;
    checkOutput("late_ack_halt", {31'b0, halted}, 32'd0);
    checkOutput("late_ack_instr", instr, 32'h0);
    checkOutput("late_ack_req", {31'b0, imem_req}, 32'd1);

    // Random program: PC follows pc+4 or the branch target, halting on bad opcode/target
    doReset();
    mpc = 32'h0;
    for (int k = 0; k < 60; k++) begin
      rnd = $urandom;
      if ($urandom_range(0, 9) == 0) begin
        do op = 7'($urandom_range(0, 127)); while (isLegal(op));
      end else begin
        op = legalOps[$urandom_range(0, 3)];
      end
      v.word     = {rnd[31:7], op};
      v.ackDelay = $urandom_range(0, 3);
      v.exDelay  = $urandom_range(0, 3);
      v.taken    = 1'($urandom_range(0, 1));
      rnd        = $urandom;
      v.target   = {rnd[31:2], 2'b00};
      if ($urandom_range(0, 7) == 0) v.target[1:0] = 2'($urandom_range(1, 3));
      v.expPc    = mpc;
      v.expOp    = op;
      if (!isLegal(op))                          v.expKind = KIND_ILLEGAL;
      else if (v.taken && v.target[1:0] != 2'b0) v.expKind = KIND_MISALIGNED;
      else                                       v.expKind = KIND_OK;
      v.expNext  = v.taken ? v.target : mpc + 32'd4;
      applyStimulus(v);
      if (v.expKind != KIND_OK) begin
        doReset();
        mpc = 32'h0;
      end else begin
        mpc = v.expNext;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
